// File: rtl/bet_entry_pkg.sv
// Shared types and constants for the player-1 bet entry front-end.
package bet_entry_pkg;

  localparam int BET_W   = 6;
  // One extra bit so that pending + step never wraps before saturation.
  localparam int ARITH_W = BET_W + 1;

  // Step size indexed by the debounced sw_step code: 00=1, 01=2, 10=5, 11=10.
  localparam logic [3:0][3:0] STEP_LUT = {4'd10, 4'd5, 4'd2, 4'd1};

  typedef enum logic {
    EDIT   = 1'b0,
    LOCKED = 1'b1
  } bet_state_e;

  function automatic logic [ARITH_W-1:0] step_size(input logic [1:0] sel);
    return {3'b000, STEP_LUT[sel]};
  endfunction

endpackage

// File: rtl/bet_entry_ctrl_if.sv
// Board-side signal bundle of the bet entry controller.
interface bet_entry_ctrl_if;
  import bet_entry_pkg::*;

  logic             btn_inc_n;
  logic             btn_dec_n;
  logic             btn_confirm_n;
  logic [1:0]       sw_step;
  logic [BET_W-1:0] bet_cap;
  logic             bet_lock;
  logic [BET_W-1:0] bet_pending;
  logic [BET_W-1:0] bet_datac;
  logic             bet_commit;
  logic             bet_locked;

  modport master (
    output btn_inc_n, btn_dec_n, btn_confirm_n, sw_step, bet_cap, bet_lock,
    input  bet_pending, bet_datac, bet_commit, bet_locked
  );

  modport slave (
    input  btn_inc_n, btn_dec_n, btn_confirm_n, sw_step, bet_cap, bet_lock,
    output bet_pending, bet_datac, bet_commit, bet_locked
  );

endinterface

// File: rtl/bet_entry_ctrl_debounce_sync.sv
// Two-flop synchroniser followed by a stable-count debouncer.
// din is active-high; level starts released (0) and only moves after
// DEBOUNCE_CYCLES consecutive synchronised samples disagree with it.
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count disagreeing samples; any agreeing sample restarts the run.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser and debounce state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/bet_entry_ctrl.sv
// Player-1 bet entry: debounced up/down editing with auto-repeat and
// saturation, confirm-to-commit, and a lock while a round is in progress.
//
//   state  | meaning
//   EDIT   | steps, confirm and cap clamping are applied
//   LOCKED | betting closed; pending/committed values held, repeat idle
module bet_entry_ctrl
  import bet_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int MAX_BET         = 63
) (
  input  logic             clk,
  input  logic             reset_n,
  bet_entry_ctrl_if.slave  bus
);

  localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [ARITH_W-1:0] MAX_BET_A = ARITH_W'(MAX_BET);

  // Index 0 is increment, index 1 is decrement.
  logic [1:0] btn_lvl, btn_rise;
  logic       conf_lvl_unused, conf_rise;
  logic [1:0] sw_lvl, sw_rise_unused;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .reset_n(reset_n), .din(~bus.btn_inc_n),
    .level(btn_lvl[0]), .rise(btn_rise[0]));
  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk(clk), .reset_n(reset_n), .din(~bus.btn_dec_n),
    .level(btn_lvl[1]), .rise(btn_rise[1]));
  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_conf (
    .clk(clk), .reset_n(reset_n), .din(~bus.btn_confirm_n),
    .level(conf_lvl_unused), .rise(conf_rise));
  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw0 (
    .clk(clk), .reset_n(reset_n), .din(bus.sw_step[0]),
    .level(sw_lvl[0]), .rise(sw_rise_unused[0]));
  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw1 (
    .clk(clk), .reset_n(reset_n), .din(bus.sw_step[1]),
    .level(sw_lvl[1]), .rise(sw_rise_unused[1]));

  bet_state_e             state_q, state_d;
  logic [BET_W-1:0]       pending_q, pending_d;
  logic [BET_W-1:0]       datac_q, datac_d;
  logic                   commit_q, commit_d;
  logic [1:0][RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic [1:0]             rpt_act_q, rpt_act_d;
  logic [1:0]             fire;
  logic [ARITH_W-1:0]     cap_eff, step_amt, work;

  assign cap_eff  = ({1'b0, bus.bet_cap} > MAX_BET_A) ? MAX_BET_A : {1'b0, bus.bet_cap};
  assign step_amt = step_size(sw_lvl);

  // Auto-repeat: step on press, again after the hold time, then periodically.
  // A press is only armed while editing, so a button held through a lock
  // stays silent until it is released and pressed again.
  always_comb begin
    rpt_cnt_d = '0;
    rpt_act_d = '0;
    fire      = '0;
    for (int b = 0; b < 2; b++) begin
      if (state_q == EDIT && !bus.bet_lock && btn_lvl[b]) begin
        if (btn_rise[b]) begin
          fire[b]      = 1'b1;
          rpt_act_d[b] = 1'b1;
          rpt_cnt_d[b] = RPT_W'(HOLD_CYCLES - 1);
        end else if (rpt_act_q[b]) begin
          rpt_act_d[b] = 1'b1;
          if (rpt_cnt_q[b] == '0) begin
            fire[b]      = 1'b1;
            rpt_cnt_d[b] = RPT_W'(REPEAT_CYCLES - 1);
          end else begin
            rpt_cnt_d[b] = rpt_cnt_q[b] - 1'b1;
          end
        end
      end
    end
  end

  // FSM next state, saturating step arithmetic, commit and unlock reload.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    datac_d   = datac_q;
    commit_d  = 1'b0;
    work      = {1'b0, pending_q};
    case (state_q)
      EDIT: begin
        if (bus.bet_lock) begin
          state_d = LOCKED;
        end else begin
          if (work > cap_eff) work = cap_eff;
          if (conf_rise) begin
            datac_d  = pending_q;
            commit_d = 1'b1;
          end
          if (fire[0] && !fire[1]) begin
            work = (work + step_amt > cap_eff) ? cap_eff : work + step_amt;
          end else if (fire[1] && !fire[0]) begin
            work = (work > step_amt) ? work - step_amt : '0;
          end
          pending_d = work[BET_W-1:0];
        end
      end
      LOCKED: begin
        if (!bus.bet_lock) begin
          state_d   = EDIT;
          pending_d = datac_q;
        end
      end
      default: state_d = EDIT;
    endcase
  end

  // Registered state and outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= EDIT;
      pending_q <= '0;
      datac_q   <= '0;
      commit_q  <= 1'b0;
      rpt_cnt_q <= '0;
      rpt_act_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      datac_q   <= datac_d;
      commit_q  <= commit_d;
      rpt_cnt_q <= rpt_cnt_d;
      rpt_act_q <= rpt_act_d;
    end
  end

  assign bus.bet_pending = pending_q;
  assign bus.bet_datac   = datac_q;
  assign bus.bet_commit  = commit_q;
  assign bus.bet_locked  = (state_q == LOCKED);

endmodule

// File: tb/tb_bet_entry_ctrl.sv
// Bench for bet_entry_ctrl with short debounce/hold/repeat times. A
// behavioural model derives debounced levels from the raw input history,
// repeat steps from time held since the press, and the bet from the rules.
module tb_bet_entry_ctrl;
  import bet_entry_pkg::*;

  localparam int DB   = 4;
  localparam int HOLD = 16;
  localparam int RPT  = 4;
  localparam int MAXB = 63;
  localparam int HMAX = 16384;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  bet_entry_ctrl_if bus();

  bet_entry_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(RPT),
    .MAX_BET(MAXB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // raw_hist[ch][k]: active level of raw input ch seen at edge k since reset.
  // Channels: 0 inc, 1 dec, 2 confirm, 3 sw_step[0], 4 sw_step[1].
  bit raw_hist [5][HMAX];
  int cyc;
  bit lvl_m  [5];
  bit rise_m [5];
  bit act_m  [2];
  int t_m    [2];
  bit locked_m;
  int pend_m, datac_m;
  bit commit_m;

  function automatic bit raw_active(input int ch);
    case (ch)
      0: return !bus.btn_inc_n;
      1: return !bus.btn_dec_n;
      2: return !bus.btn_confirm_n;
      3: return bus.sw_step[0];
      default: return bus.sw_step[1];
    endcase
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int c = 0; c < 5; c++) begin
      lvl_m[c]  = 1'b0;
      rise_m[c] = 1'b0;
    end
    for (int b = 0; b < 2; b++) begin
      act_m[b] = 1'b0;
      t_m[b]   = 0;
    end
    locked_m = 1'b0;
    pend_m   = 0;
    datac_m  = 0;
    commit_m = 1'b0;
  endtask

  task automatic model_edge();
    bit fire [2];
    int cap, st, p, sel;
    bit all_diff, s;
    cyc++;
    sel = {lvl_m[4], lvl_m[3]};
    case (sel)
      0: st = 1;
      1: st = 2;
      2: st = 5;
      default: st = 10;
    endcase
    for (int b = 0; b < 2; b++) begin
      fire[b] = 1'b0;
      if (locked_m || bus.bet_lock || !lvl_m[b]) begin
        act_m[b] = 1'b0;
      end else if (rise_m[b]) begin
        fire[b] = 1'b1;
        act_m[b] = 1'b1;
        t_m[b] = 0;
      end else if (act_m[b]) begin
        t_m[b]++;
        fire[b] = (t_m[b] >= HOLD) && (((t_m[b] - HOLD) % RPT) == 0);
      end
    end
    commit_m = 1'b0;
    if (locked_m) begin
      if (!bus.bet_lock) begin
        locked_m = 1'b0;
        pend_m = datac_m;
      end
    end else if (bus.bet_lock) begin
      locked_m = 1'b1;
    end else begin
      cap = (int'(bus.bet_cap) < MAXB) ? int'(bus.bet_cap) : MAXB;
      p = (pend_m < cap) ? pend_m : cap;
      if (rise_m[2]) begin
        datac_m = pend_m;
        commit_m = 1'b1;
      end
      if (fire[0] && !fire[1]) p = (p + st > cap) ? cap : p + st;
      else if (fire[1] && !fire[0]) p = (p - st < 0) ? 0 : p - st;
      pend_m = p;
    end
    // Debounced level flips once the last DB samples (two-edge delayed) all disagree.
    for (int ch = 0; ch < 5; ch++) begin
      if (cyc < HMAX) raw_hist[ch][cyc] = raw_active(ch);
      rise_m[ch] = 1'b0;
      if (cyc >= DB) begin
        all_diff = 1'b1;
        for (int j = cyc - DB + 1; j <= cyc; j++) begin
          s = (j > 2) ? raw_hist[ch][j-2] : 1'b0;
          if (s == lvl_m[ch]) all_diff = 1'b0;
        end
        if (all_diff) begin
          lvl_m[ch]  = !lvl_m[ch];
          rise_m[ch] = lvl_m[ch];
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    @(negedge clk);
    check("pending", int'(bus.bet_pending), pend_m);
    check("datac",   int'(bus.bet_datac),   datac_m);
    check("commit",  int'(bus.bet_commit),  int'(commit_m));
    check("locked",  int'(bus.bet_locked),  int'(locked_m));
  endtask

  task automatic set_btn(input int ch, input bit pressed);
    case (ch)
      0: bus.btn_inc_n = !pressed;
      1: bus.btn_dec_n = !pressed;
      default: bus.btn_confirm_n = !pressed;
    endcase
  endtask

  task automatic press(input int ch, input int hold, input int gap);
    set_btn(ch, 1'b1);
    repeat (hold) tick();
    set_btn(ch, 1'b0);
    repeat (gap) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rem [3];
    bit prs [3];
    int sw_rem, cap_rem, lock_rem;

    bus.btn_inc_n = 1'b1;
    bus.btn_dec_n = 1'b1;
    bus.btn_confirm_n = 1'b1;
    bus.sw_step = 2'b10;
    bus.bet_cap = 6'd63;
    bus.bet_lock = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_pending", int'(bus.bet_pending), 0);
    check("rst_datac",   int'(bus.bet_datac), 0);
    check("rst_locked",  int'(bus.bet_locked), 0);
    reset_n = 1'b1;
    repeat (10) tick();

    // Clean press at step 5: pending moves exactly 2+DB+1 edges after the press.
    set_btn(0, 1'b1);
    repeat (6) tick();
    check("p1_before", int'(bus.bet_pending), 0);
    tick();
    check("p1_after", int'(bus.bet_pending), 5);
    repeat (5) tick();
    set_btn(0, 1'b0);
    repeat (12) tick();
    check("p1_datac", int'(bus.bet_datac), 0);

    // Glitches shorter than the debounce window do nothing; then auto-repeat at step 1.
    bus.sw_step = 2'b00;
    repeat (10) tick();
    repeat (3) press(0, 3, 3);
    repeat (10) tick();
    check("glitch", int'(bus.bet_pending), 5);
    set_btn(0, 1'b1);
    repeat (40) tick();
    check("repeat_held", int'(bus.bet_pending), 11);
    set_btn(0, 1'b0);
    repeat (10) tick();
    check("repeat_rel", int'(bus.bet_pending), 12);

    // Saturation at the top, then cap clamping.
    bus.sw_step = 2'b11;
    repeat (10) tick();
    repeat (6) press(0, 8, 10);
    check("sat_top", int'(bus.bet_pending), 63);
    bus.bet_cap = 6'd20;
    tick();
    check("cap_clamp", int'(bus.bet_pending), 20);
    check("cap_datac", int'(bus.bet_datac), 0);
    bus.bet_cap = 6'd63;
    repeat (3) tick();

    // Confirm, then confirm together with inc (commit takes the pre-step value).
    press(2, 8, 10);
    check("confirm", int'(bus.bet_datac), 20);
    set_btn(0, 1'b1);
    set_btn(2, 1'b1);
    repeat (8) tick();
    set_btn(0, 1'b0);
    set_btn(2, 1'b0);
    repeat (10) tick();
    check("conf_inc_datac", int'(bus.bet_datac), 20);
    check("conf_inc_pend", int'(bus.bet_pending), 30);

    // Decrement saturates at zero.
    repeat (4) press(1, 8, 10);
    check("sat_zero", int'(bus.bet_pending), 0);

    // Lock ignores input; unlock restores the committed value.
    bus.bet_lock = 1'b1;
    tick();
    check("lock_flag", int'(bus.bet_locked), 1);
    press(0, 8, 10);
    press(2, 8, 10);
    check("lock_pend", int'(bus.bet_pending), 0);
    check("lock_datac", int'(bus.bet_datac), 20);
    bus.bet_lock = 1'b0;
    tick();
    check("unlock_flag", int'(bus.bet_locked), 0);
    check("unlock_pend", int'(bus.bet_pending), 20);

    // A button held across unlock generates no step.
    bus.bet_lock = 1'b1;
    set_btn(0, 1'b1);
    repeat (20) tick();
    bus.bet_lock = 1'b0;
    repeat (30) tick();
    check("held_unlock", int'(bus.bet_pending), 20);
    set_btn(0, 1'b0);
    repeat (10) tick();

    // Randomised traffic against the model.
    for (int b = 0; b < 3; b++) begin
      rem[b] = 0;
      prs[b] = 1'b0;
    end
    sw_rem = 0;
    cap_rem = 0;
    lock_rem = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          prs[b] = !prs[b];
          if (prs[b]) rem[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 60);
          else rem[b] = (b == 2) ? $urandom_range(20, 120) : $urandom_range(1, 30);
        end
        set_btn(b, prs[b]);
        rem[b]--;
      end
      if (sw_rem == 0) begin
        bus.sw_step = 2'($urandom_range(0, 3));
        sw_rem = $urandom_range(20, 300);
      end
      sw_rem--;
      if (cap_rem == 0) begin
        bus.bet_cap = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd63;
        cap_rem = $urandom_range(10, 200);
      end
      cap_rem--;
      if (lock_rem == 0) begin
        bus.bet_lock = ($urandom_range(0, 4) == 0);
        lock_rem = bus.bet_lock ? $urandom_range(5, 40) : $urandom_range(20, 300);
      end
      lock_rem--;
      tick();
    end
    for (int b = 0; b < 3; b++) set_btn(b, 1'b0);
    bus.bet_lock = 1'b0;
    bus.bet_cap = 6'd63;
    bus.sw_step = 2'b00;
    repeat (20) tick();

    // Asynchronous reset in the middle of auto-repeat.
    press(2, 8, 10);
    set_btn(0, 1'b1);
    repeat (30) tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("arst_pending", int'(bus.bet_pending), 0);
    check("arst_datac",   int'(bus.bet_datac), 0);
    check("arst_commit",  int'(bus.bet_commit), 0);
    check("arst_locked",  int'(bus.bet_locked), 0);
    set_btn(0, 1'b0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (30) tick();
    check("post_rst_idle", int'(bus.bet_pending), 0);
    press(0, 8, 10);
    check("post_rst_press", int'(bus.bet_pending), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bet_entry_ctrl.md
Name: bet_entry_ctrl

Overview:
Front-end for the player-1 bet. It takes the raw board push-buttons and slide switches, debounces them, and lets the player edit a pending bet with up/down buttons. The bet is edited with step size, auto-repeat and saturation. On confirm, the pending value is committed to a held 6-bit output that drives the system's bet1_0 conduit input (datac[5:0]).

Parameters:
DEBOUNCE_CYCLES, 500000, cycles an input must be stable before its debounced level changes (10 ms at 50 MHz)
HOLD_CYCLES, 25000000, held-button cycles before auto-repeat starts
REPEAT_CYCLES, 5000000, cycles between auto-repeat steps
MAX_BET, 63, absolute upper bound of bet (must be <= 63)

Ports:
clk  input  1  system clock (50 MHz domain of clk_clk)
reset_n  input  1  asynchronous active-low reset
btn_inc_n  input  1  raw increment button, active-low, asynchronous to clk
btn_dec_n  input  1  raw decrement button, active-low, asynchronous
btn_confirm_n  input  1  raw confirm button, active-low, asynchronous
sw_step  input  2  raw step select: 00=1, 01=2, 10=5, 11=10
bet_cap  input  6  current allowed maximum (player balance), synchronous
bet_lock  input  1  synchronous; 1 = betting closed (round in progress)
bet_pending  output  6  value being edited (for HEX display)
bet_datac  output  6  committed bet, held; connects to bet1_0_conduit_end_datac
bet_commit  output  1  one-cycle pulse when bet_datac is updated
bet_locked  output  1  1 while FSM is in LOCKED

Behaviour:
- Reset (async assert, sync release): bet_pending=0, bet_datac=0, bet_commit=0, bet_locked=0, FSM=EDIT, all debounce and repeat counters=0, debounced levels=released.
- Each button and sw_step passes through a 2-FF synchroniser, then a debouncer. The debounced level updates only after DEBOUNCE_CYCLES consecutive identical synchronised samples. Input-to-debounced latency is 2 + DEBOUNCE_CYCLES cycles.
- A press event is the rising edge of the debounced active level, one cycle wide.
- Effective cap is min(bet_cap, MAX_BET).
- Auto-repeat, inc or dec:
  - Press event gives one step.
  - If the button is still held, a further step occurs HOLD_CYCLES after the press.
  - Steps then repeat every REPEAT_CYCLES until release.
  - Release clears the repeat counter.
- Step arithmetic is done 7 bits wide:
  - inc: pending = min(pending + step, cap).
  - dec: pending = max(pending - step, 0).
  - Saturation applies; the value never wraps.
- inc and dec step events in the same cycle: no change; both repeat counters keep running.
- If bet_cap drops below bet_pending, bet_pending clamps to cap on the next cycle. bet_datac is not altered.
- FSM states:
  - EDIT: steps are applied. A confirm press event loads bet_datac <= bet_pending (the pre-step value if a step occurs in the same cycle) and pulses bet_commit for 1 cycle. The FSM stays in EDIT.
  - EDIT -> LOCKED when bet_lock=1. Any step or confirm in that cycle is discarded.
  - LOCKED: bet_locked=1. Steps, confirm and cap clamping are ignored; bet_pending and bet_datac are held; repeat counters are held at 0.
  - LOCKED -> EDIT when bet_lock=0. bet_pending <= bet_datac, so editing resumes from the committed value.
- A button held across the LOCKED->EDIT transition generates no step until it is released and pressed again.
- All outputs are registered. A step updates bet_pending 1 cycle after its press event, and bet_datac/bet_commit likewise.
- Reset mid-operation returns everything to reset values immediately; any press in progress is forgotten.

Decomposition:
- Package bet_entry_pkg:
  - BET_W=6
  - step lookup constant (1, 2, 5, 10) indexed by sw_step
  - FSM state typedef {EDIT, LOCKED}
- Sub-module debounce_sync: 2-FF synchroniser plus stable-count debouncer, parameter DEBOUNCE_CYCLES. It outputs a debounced level and a rise pulse.
  - Instantiated once per button.
  - sw_step uses two instances with level output only.
- The top level holds the repeat counters, arithmetic and FSM.

Test Plan (sim with DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_CYCLES=4, bet_cap=63):
1. Reset, sw_step=10, one clean inc press -> bet_pending 0->5 exactly 2+4+1 cycles after press; bet_datac stays 0, bet_commit never high.
2. inc with 3-cycle glitch pulses then release -> no change; a held inc for 40 cycles at step 1 -> pending 1, then +1 at hold 16 and every 4 cycles after (1, 2, 3, ...); no wrap.
3. pending=60, sw_step=11, inc -> 63; dec at pending=3, step 10 -> 0; bet_cap set to 20 while pending=63 -> pending=20 next cycle, bet_datac unchanged.
4. pending=12, confirm press -> bet_datac=12, bet_commit high exactly 1 cycle; confirm and inc in same cycle -> bet_datac=12, pending=13.
5. bet_lock=1, then inc/confirm presses -> no change, bet_locked=1; edit pending to 30, commit 12, lock, unlock -> pending=12.
6. Assert reset_n low mid auto-repeat with pending=40, bet_datac=25 -> all outputs 0 asynchronously; after release no steps until a fresh press.
